// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for the icache refill and dcache fill/writeback paths
// sharing one line-wide memory port, with a memory-latency watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int LINE_W         = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [1:0]        i_r_valid,
    input  logic              i_r0_rw,
    input  logic              i_r1_rw,
    input  logic [ADDR_W-1:0] i_r0_addr,
    input  logic [ADDR_W-1:0] i_r1_addr,
    input  logic [LINE_W-1:0] i_r0_wdata,
    input  logic [LINE_W-1:0] i_r1_wdata,
    output logic [1:0]        o_r_resp,
    output logic [LINE_W-1:0] o_r_resp_data,
    output logic              o_r_resp_err,
    output logic              o_mem_valid,
    output logic              o_mem_rw,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [LINE_W-1:0] o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic [LINE_W-1:0] i_mem_rdata,
    output logic [1:0]        o_owner,
    output logic              o_busy,
    output logic              o_timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            r_state;
    logic              r_rr_last;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_resp;
    logic [LINE_W-1:0] r_resp_data;
    logic              r_resp_err;
    logic              r_mem_valid;
    logic              r_mem_rw;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;
    logic [1:0]        r_owner;
    logic              r_busy;
    logic              r_timeout_err;

    logic              w_win;
    logic              w_rw;
    logic [ADDR_W-1:0] w_addr;
    logic [LINE_W-1:0] w_wdata;
    logic              w_limit;

    // On a tie the requester that did not win last time gets the port.
    assign w_win   = (&i_r_valid) ? ~r_rr_last : i_r_valid[1];
    assign w_rw    = w_win ? i_r1_rw    : i_r0_rw;
    assign w_addr  = w_win ? i_r1_addr  : i_r0_addr;
    assign w_wdata = w_win ? i_r1_wdata : i_r0_wdata;
    assign w_limit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_rr_last     <= 1'b0;
            r_cnt         <= '0;
            r_resp        <= 2'b00;
            r_resp_data   <= '0;
            r_resp_err    <= 1'b0;
            r_mem_valid   <= 1'b0;
            r_mem_rw      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_owner       <= 2'b00;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|i_r_valid) begin
                        r_mem_valid <= 1'b1;
                        r_mem_rw    <= w_rw;
                        r_mem_addr  <= w_addr & ~ADDR_W'(15);
                        r_mem_wdata <= w_wdata;
                        r_owner     <= w_win ? 2'b10 : 2'b01;
                        r_rr_last   <= w_win;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    // A completion on the limit cycle still counts as success.
                    if (i_mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_resp_data <= r_mem_rw ? '0 : i_mem_rdata;
                        r_resp      <= r_owner;
                        r_resp_err  <= 1'b0;
                        r_state     <= RESP;
                    end else if (w_limit) begin
                        r_mem_valid   <= 1'b0;
                        r_resp_data   <= '0;
                        r_resp        <= r_owner;
                        r_resp_err    <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_resp      <= 2'b00;
                    r_resp_data <= '0;
                    r_resp_err  <= 1'b0;
                    r_owner     <= 2'b00;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_r_resp      = r_resp;
    assign o_r_resp_data = r_resp_data;
    assign o_r_resp_err  = r_resp_err;
    assign o_mem_valid   = r_mem_valid;
    assign o_mem_rw      = r_mem_rw;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_owner       = r_owner;
    assign o_busy        = r_busy;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized two-requester
// traffic checked against a line-memory model and expected grant order.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic          rw0 = 1'b0, rw1 = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [LW-1:0] wd0 = '0, wd1 = '0;
    logic          mem_ready = 1'b0;
    logic [LW-1:0] mem_rdata = '0;

    logic [1:0]    o_r_resp;
    logic [LW-1:0] o_r_resp_data;
    logic          o_r_resp_err;
    logic          o_mem_valid;
    logic          o_mem_rw;
    logic [AW-1:0] o_mem_addr;
    logic [LW-1:0] o_mem_wdata;
    logic [1:0]    o_owner;
    logic          o_busy;
    logic          o_timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mem_lat = 2;     // -1: never answer, -2: random 0..4 per transaction
    int n_err_resp = 0;
    int grants[$];
    int gcyc[$];
    logic [LW-1:0] mem    [bit [31:0]];
    logic [LW-1:0] wmodel [bit [31:0]];

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clock(clk), .i_reset(rst), .i_r_valid({v1, v0}),
        .i_r0_rw(rw0), .i_r1_rw(rw1), .i_r0_addr(a0), .i_r1_addr(a1),
        .i_r0_wdata(wd0), .i_r1_wdata(wd1),
        .o_r_resp(o_r_resp), .o_r_resp_data(o_r_resp_data), .o_r_resp_err(o_r_resp_err),
        .o_mem_valid(o_mem_valid), .o_mem_rw(o_mem_rw), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
        .o_owner(o_owner), .o_busy(o_busy), .o_timeout_err(o_timeout_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [LW-1:0] line_init(input logic [31:0] a);
        return {4{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [LW-1:0] exp_read(input logic [31:0] a);
        logic [31:0] l;
        l = a & ~32'hF;
        return wmodel.exists(l) ? wmodel[l] : line_init(l);
    endfunction

    // Memory: answers lat cycles after the first mem_valid cycle.
    initial begin
        int k, lat;
        k = 0; lat = 0;
        forever begin
            @(negedge clk);
            if (o_mem_valid && !rst) begin
                k++;
                if (k == 1) lat = (mem_lat == -2) ? int'($urandom_range(0, 4)) : mem_lat;
                if (lat >= 0 && k == lat + 1) begin
                    mem_ready = 1'b1;
                    if (o_mem_rw) begin
                        mem[o_mem_addr] = o_mem_wdata;
                        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                    end else begin
                        mem_rdata = mem.exists(o_mem_addr) ? mem[o_mem_addr] : line_init(o_mem_addr);
                    end
                end else begin
                    mem_ready = 1'b0;
                end
            end else begin
                k = 0;
                mem_ready = 1'b0;
            end
        end
    end

    // Grant log, per-grant request capture check and structural invariants.
    initial begin
        logic prev_mv;
        int gid;
        logic [AW-1:0] ea;
        prev_mv = 1'b0;
        forever begin
            @(negedge clk);
            n_tests++;
            if (o_r_resp === 2'b11 || !(o_owner inside {2'b00, 2'b01, 2'b10})) begin
                n_fail++;
                $display("FAIL onehot: r_resp=%b owner=%b at cyc %0d", o_r_resp, o_owner, cyc);
            end
            if (|o_r_resp && o_r_resp_err) n_err_resp++;
            if (o_mem_valid && !prev_mv) begin
                gid = (o_owner == 2'b10) ? 1 : 0;
                grants.push_back(gid);
                gcyc.push_back(cyc);
                ea = (gid == 1 ? a1 : a0) & ~32'hF;
                n_tests++;
                if (o_mem_addr !== ea || o_mem_rw !== (gid == 1 ? rw1 : rw0) ||
                    (o_mem_rw && o_mem_wdata !== (gid == 1 ? wd1 : wd0))) begin
                    n_fail++;
                    $display("FAIL grant_capture: req%0d addr=%h rw=%b expected addr=%h rw=%b",
                             gid, o_mem_addr, o_mem_rw, ea, (gid == 1 ? rw1 : rw0));
                end
            end
            prev_mv = o_mem_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drop(input int id);
        if (id == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    // Raises valid with the given request and waits for its response pulse.
    task automatic do_req(input int id, input bit rw, input logic [31:0] addr,
                          input logic [LW-1:0] wd, output logic [LW-1:0] rd,
                          output logic err, output bit ok, output int rc);
        if (id == 0) begin rw0 = rw; a0 = addr; wd0 = wd; v0 = 1'b1; end
        else         begin rw1 = rw; a1 = addr; wd1 = wd; v1 = 1'b1; end
        ok = 1'b0; rd = '0; err = 1'b0; rc = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (o_r_resp[id]) begin
                rd = o_r_resp_data; err = o_r_resp_err; ok = 1'b1; rc = cyc;
                break;
            end
        end
    endtask

    task automatic run_requester(input int id, input int n, input bit gaps);
        logic [LW-1:0] rd, ex, wd;
        logic err;
        bit ok, rw;
        int rc;
        logic [31:0] addr;
        for (int i = 0; i < n; i++) begin
            rw   = (id == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            addr = (id == 1) ? 32'h0080_0000 + (32'($urandom_range(0, 7)) << 4) + 32'($urandom_range(0, 15))
                             : 32'h0010_0000 + (32'($urandom_range(0, 255)) << 4) + 32'($urandom_range(0, 15));
            wd   = {$urandom, $urandom, $urandom, $urandom};
            ex   = rw ? '0 : exp_read(addr);
            do_req(id, rw, addr, wd, rd, err, ok, rc);
            n_tests++;
            if (!ok || err !== 1'b0 || rd !== ex) begin
                n_fail++;
                $display("FAIL req%0d_txn%0d: ok=%0b err=%b data=%h expected ok=1 err=0 data=%h",
                         id, i, ok, err, rd, ex);
            end
            if (ok && rw) wmodel[addr & ~32'hF] = wd;
            if (i == n - 1 || gaps) drop(id);
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({o_r_resp, o_r_resp_err, o_mem_valid, o_mem_rw, o_owner, o_busy, o_timeout_err} !== 9'b0 ||
            o_r_resp_data !== '0 || o_mem_addr !== '0 || o_mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: resp=%b mv=%b owner=%b busy=%b terr=%b expected all 0",
                     o_r_resp, o_mem_valid, o_owner, o_busy, o_timeout_err);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_busy !== 1'b0 || o_mem_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b mv=%b expected 0 0", o_busy, o_mem_valid);
        end
    endtask

    task automatic test_single_read();
        logic [LW-1:0] val;
        bit e_mv, e_busy;
        logic [1:0] e_resp;
        apply_reset();
        val = {{30{4'hA}}, 8'h01};
        mem[32'h0000_1230] = val;
        mem_lat = 3;
        rw0 = 1'b0; a0 = 32'h0000_1234; v0 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            e_mv   = (c >= 1 && c <= 4);
            e_busy = (c >= 1 && c <= 5);
            e_resp = (c == 5) ? 2'b01 : 2'b00;
            n_tests++;
            if (o_mem_valid !== e_mv || o_busy !== e_busy || o_r_resp !== e_resp) begin
                n_fail++;
                $display("FAIL single_read_c%0d: mv=%b busy=%b resp=%b expected %b %b %b",
                         c, o_mem_valid, o_busy, o_r_resp, e_mv, e_busy, e_resp);
            end
            if (c == 1) begin
                n_tests++;
                if (o_mem_addr !== 32'h0000_1230 || o_mem_rw !== 1'b0 || o_owner !== 2'b01) begin
                    n_fail++;
                    $display("FAIL single_read_req: addr=%h rw=%b owner=%b expected 00001230 0 01",
                             o_mem_addr, o_mem_rw, o_owner);
                end
            end
            if (c == 5) begin
                n_tests++;
                if (o_r_resp_data !== val || o_r_resp_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_read_data: data=%h err=%b expected %h 0", o_r_resp_data, o_r_resp_err, val);
                end
                v0 = 1'b0;
            end
        end
    endtask

    task automatic test_write();
        logic [LW-1:0] dw;
        bit seen;
        dw = 128'hDEAD_C0DE_1234_5678_9ABC_DEF0_0BAD_BEEF;
        mem_lat = 1;
        rw1 = 1'b1; a1 = 32'h0000_0040; wd1 = dw; v1 = 1'b1;
        @(negedge clk);
        n_tests++;
        if (o_mem_valid !== 1'b1 || o_mem_rw !== 1'b1 || o_mem_addr !== 32'h40 ||
            o_mem_wdata !== dw || o_owner !== 2'b10) begin
            n_fail++;
            $display("FAIL write_req: mv=%b rw=%b addr=%h wdata=%h owner=%b expected 1 1 40 %h 10",
                     o_mem_valid, o_mem_rw, o_mem_addr, o_mem_wdata, o_owner, dw);
        end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (|o_r_resp) begin
                seen = 1'b1;
                n_tests++;
                if (o_r_resp !== 2'b10 || o_r_resp_data !== '0 || o_r_resp_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL write_resp: resp=%b data=%h err=%b expected 10 0 0",
                             o_r_resp, o_r_resp_data, o_r_resp_err);
                end
            end
        end
        v1 = 1'b0;
        wmodel[32'h40] = dw;
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL write_timeout: no r_resp within 20 cycles");
        end
    endtask

    task automatic test_tie();
        logic [LW-1:0] rd0, rd1;
        logic e0, e1;
        bit ok0, ok1;
        int rc0, rc1;
        apply_reset();
        mem_lat = 2;
        grants.delete(); gcyc.delete();
        fork
            do_req(1, 1'b0, 32'h0000_2200, '0, rd1, e1, ok1, rc1);
            do_req(0, 1'b0, 32'h0000_3300, '0, rd0, e0, ok0, rc0);
        join
        drop(0); drop(1);
        n_tests++;
        if (grants.size() != 2 || grants[0] != 1 || grants[1] != 0) begin
            n_fail++;
            $display("FAIL tie_order: got %0d grants first=%0d expected 1 then 0",
                     grants.size(), grants.size() > 0 ? grants[0] : -1);
        end
        n_tests++;
        if (gcyc.size() != 2 || gcyc[1] != rc1 + 2) begin
            n_fail++;
            $display("FAIL tie_regrant: icache grant cyc=%0d expected %0d",
                     gcyc.size() > 1 ? gcyc[1] : -1, rc1 + 2);
        end
        n_tests++;
        if (!ok0 || !ok1 || rd0 !== exp_read(32'h3300) || rd1 !== exp_read(32'h2200)) begin
            n_fail++;
            $display("FAIL tie_data: ok=%0b%0b d0=%h d1=%h", ok0, ok1, rd0, rd1);
        end
    endtask

    task automatic test_contention();
        int errs;
        apply_reset();
        mem_lat = 1;
        grants.delete();
        errs = n_err_resp;
        fork
            run_requester(0, 3, 1'b0);
            run_requester(1, 3, 1'b0);
        join
        n_tests++;
        if (grants.size() != 6 || grants[0] != 1 || grants[1] != 0 || grants[2] != 1 ||
            grants[3] != 0 || grants[4] != 1 || grants[5] != 0) begin
            n_fail++;
            $display("FAIL contention_order: %0d grants, order %p expected 1,0,1,0,1,0",
                     grants.size(), grants);
        end
        n_tests++;
        if (n_err_resp != errs) begin
            n_fail++;
            $display("FAIL contention_err: %0d error responses expected 0", n_err_resp - errs);
        end
    endtask

    task automatic test_timeout();
        int mv_cnt;
        bit seen;
        logic [LW-1:0] rd;
        logic err;
        bit ok;
        int rc;
        mem_lat = -1;
        mv_cnt = 0; seen = 1'b0;
        rw0 = 1'b0; a0 = 32'h0000_5550; v0 = 1'b1;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (o_mem_valid) mv_cnt++;
            if (|o_r_resp) begin
                seen = 1'b1;
                n_tests++;
                if (o_r_resp !== 2'b01 || o_r_resp_err !== 1'b1 || o_r_resp_data !== '0 || o_timeout_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_resp: resp=%b err=%b data=%h terr=%b expected 01 1 0 1",
                             o_r_resp, o_r_resp_err, o_r_resp_data, o_timeout_err);
                end
            end
        end
        v0 = 1'b0;
        n_tests++;
        if (!seen || mv_cnt != TO) begin
            n_fail++;
            $display("FAIL timeout_len: seen=%0b mem_valid cycles=%0d expected 1 %0d", seen, mv_cnt, TO);
        end
        mem_lat = 2;
        do_req(0, 1'b0, 32'h0000_6660, '0, rd, err, ok, rc);
        drop(0);
        n_tests++;
        if (!ok || err !== 1'b0 || rd !== exp_read(32'h6660) || o_timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_recover: ok=%0b err=%b data=%h terr=%b expected 1 0 %h 1",
                     ok, err, rd, o_timeout_err, exp_read(32'h6660));
        end
    endtask

    task automatic test_reset_mid_req();
        logic [LW-1:0] rd;
        logic err;
        bit ok;
        int rc;
        mem_lat = -1;
        rw0 = 1'b0; a0 = 32'h0000_7770; v0 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; v0 = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({o_r_resp, o_r_resp_err, o_mem_valid, o_mem_rw, o_owner, o_busy, o_timeout_err} !== 9'b0 ||
            o_mem_addr !== '0 || o_r_resp_data !== '0) begin
            n_fail++;
            $display("FAIL midreq_reset: resp=%b mv=%b owner=%b busy=%b terr=%b expected all 0",
                     o_r_resp, o_mem_valid, o_owner, o_busy, o_timeout_err);
        end
        rst = 1'b0;
        mem_lat = 2;
        rw0 = 1'b0; a0 = 32'h0000_8880; v0 = 1'b1;
        @(negedge clk);
        n_tests++;
        if (o_mem_valid !== 1'b1 || o_owner !== 2'b01 || o_mem_addr !== 32'h8880) begin
            n_fail++;
            $display("FAIL midreq_regrant: mv=%b owner=%b addr=%h expected 1 01 00008880",
                     o_mem_valid, o_owner, o_mem_addr);
        end
        do_req(0, 1'b0, 32'h0000_8880, '0, rd, err, ok, rc);
        drop(0);
        n_tests++;
        if (!ok || err !== 1'b0 || rd !== exp_read(32'h8880)) begin
            n_fail++;
            $display("FAIL midreq_data: ok=%0b err=%b data=%h expected 1 0 %h", ok, err, rd, exp_read(32'h8880));
        end
    endtask

    task automatic test_random();
        int errs;
        mem_lat = -2;
        errs = n_err_resp;
        fork
            run_requester(0, 12, 1'b1);
            run_requester(1, 12, 1'b1);
        join
        n_tests++;
        if (n_err_resp != errs) begin
            n_fail++;
            $display("FAIL random_err: %0d error responses expected 0", n_err_resp - errs);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_tie();
        test_contention();
        test_timeout();
        test_reset_mid_req();
        test_random();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
